// File: rtl/slant_link_pkg.sv
// Shared definitions for the slant link: sync patterns, sync length,
// transmitter state encoding and default frame geometry.
package slant_link_pkg;

  localparam int SYNC_LEN      = 24;
  localparam int BIT_CLKS_DEF  = 25;
  localparam int LINE_SYMS_DEF = 160;
  localparam int LINES_DEF     = 480;

  localparam logic [23:0] FRAME_EVEN = 24'haab155;
  localparam logic [23:0] FRAME_ODD  = 24'haa8d55;
  localparam logic [23:0] HSYNC      = 24'h000055;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FSYNC,
    ST_DATA,
    ST_LSYNC
  } link_state_t;

  // Sync patterns go out MSB first: symbol 0 carries bit 23.
  function automatic logic sync_bit(input logic [23:0] pattern, input logic [4:0] idx);
    return pattern[5'(SYNC_LEN - 1) - idx];
  endfunction

endpackage

// File: rtl/slant_symbol_timer.sv
// Symbol period counter. Runs 0..BIT_CLKS-1 while a frame is active and
// parks at zero otherwise, so the first symbol of a frame gets a full period.
module slant_symbol_timer
  import slant_link_pkg::*;
#(
  parameter int BIT_CLKS = BIT_CLKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sym_wrap,
  output logic fetch,
  output logic capture
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] FETCH = CNT_W'(BIT_CLKS - 2);

  logic [CNT_W-1:0] count;

  // Free-running symbol counter, cleared whenever no frame is in flight.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign sym_wrap = run && (count == LAST);
  assign fetch    = run && (count == FETCH);
  assign capture  = run && (count == LAST);

endmodule

// File: rtl/slant_transmitter.sv
// Drone-side slant symbol transmitter: frame sync, then per line a block of
// interleaved Y/C data symbols, with a line sync ahead of every line but the first.
module slant_transmitter #(
  parameter int          BIT_CLKS   = slant_link_pkg::BIT_CLKS_DEF,
  parameter int          LINE_SYMS  = slant_link_pkg::LINE_SYMS_DEF,
  parameter int          LINES      = slant_link_pkg::LINES_DEF,
  parameter logic [23:0] FRAME_EVEN = slant_link_pkg::FRAME_EVEN,
  parameter logic [23:0] FRAME_ODD  = slant_link_pkg::FRAME_ODD,
  parameter logic [23:0] HSYNC      = slant_link_pkg::HSYNC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  output logic        Busy,
  output logic        FrameOdd,
  output logic        TxRead,
  output logic [15:0] TxAddr,
  input  logic [4:0]  TxYData,
  input  logic [4:0]  TxCData,
  output logic [5:0]  Send0Data
);

  import slant_link_pkg::SYNC_LEN, slant_link_pkg::sync_bit, slant_link_pkg::link_state_t,
         slant_link_pkg::ST_IDLE, slant_link_pkg::ST_FSYNC, slant_link_pkg::ST_DATA,
         slant_link_pkg::ST_LSYNC;

  localparam int IDX_W  = $clog2((LINE_SYMS > SYNC_LEN) ? LINE_SYMS : SYNC_LEN);
  localparam int LINE_W = $clog2(LINES + 1);
  localparam logic [IDX_W-1:0]  LAST_SYNC = IDX_W'(SYNC_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_DATA = IDX_W'(LINE_SYMS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [15:0]       LINE_STEP = 16'(LINE_SYMS / 2);

  link_state_t       state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;          // symbol index within the current block
  logic [LINE_W-1:0] line, line_nx;        // line of the current or upcoming data block
  logic [15:0]       line_base, base_nx;   // line * (LINE_SYMS/2)
  logic              frame_odd, odd_nx;
  logic [5:0]        send, send_nx;

  logic              sym_wrap, fetch, capture;
  logic              next_is_data;
  logic [IDX_W-1:0]  next_sym;
  logic [4:0]        sample;
  logic [23:0]       fsync_pat, sync_pat;

  slant_symbol_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (Busy),
    .sym_wrap (sym_wrap),
    .fetch    (fetch),
    .capture  (capture)
  );

  // Frame parity only changes between frames, so it selects a stable pattern for the whole FSYNC.
  assign fsync_pat = frame_odd ? FRAME_ODD : FRAME_EVEN;
  assign sync_pat  = (state == ST_FSYNC) ? fsync_pat : HSYNC;

  // Look ahead to the symbol that loads at the next wrap, for fetching and data selection.
  always_comb begin
    next_is_data = 1'b0;
    next_sym     = '0;
    case (state)
      ST_FSYNC, ST_LSYNC: next_is_data = (idx == LAST_SYNC);
      ST_DATA: begin
        next_is_data = (idx != LAST_DATA);
        next_sym     = idx + 1'b1;
      end
      default: ;
    endcase
  end

  assign sample = next_sym[0] ? TxCData : TxYData;
  assign TxRead = fetch && next_is_data;
  assign TxAddr = line_base + 16'(next_sym >> 1);

  // Next-state logic: block sequencing on symbol wraps and the sync symbol to load.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    line_nx  = line;
    base_nx  = line_base;
    odd_nx   = frame_odd;
    send_nx  = send;
    unique case (state)
      ST_IDLE: begin
        send_nx = '0;
        if (Start) begin
          state_nx = ST_FSYNC;
          idx_nx   = '0;
          line_nx  = '0;
          base_nx  = '0;
          send_nx  = {sync_bit(fsync_pat, 5'd0), 5'b0};
        end
      end
      ST_FSYNC, ST_LSYNC: begin
        if (sym_wrap) begin
          if (idx == LAST_SYNC) begin
            state_nx = ST_DATA;
            idx_nx   = '0;
          end else begin
            idx_nx  = idx + 1'b1;
            send_nx = {sync_bit(sync_pat, idx_nx[4:0]), 5'b0};
          end
        end
      end
      ST_DATA: begin
        if (sym_wrap) begin
          if (idx == LAST_DATA) begin
            idx_nx = '0;
            if (line == LAST_LINE) begin
              state_nx = ST_IDLE;
              line_nx  = '0;
              base_nx  = '0;
              odd_nx   = ~frame_odd;
              send_nx  = '0;
            end else begin
              state_nx = ST_LSYNC;
              line_nx  = line + 1'b1;
              base_nx  = line_base + LINE_STEP;
              send_nx  = {sync_bit(HSYNC, 5'd0), 5'b0};
            end
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Pixel data fetched two counts earlier lands on the wire at the wrap.
    if (capture && next_is_data) begin
      send_nx = {1'b0, sample};
    end
  end

  // State, counters, frame parity and the registered symbol output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      line      <= '0;
      line_base <= '0;
      frame_odd <= 1'b0;
      send      <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      line      <= line_nx;
      line_base <= base_nx;
      frame_odd <= odd_nx;
      send      <= send_nx;
    end
  end

  assign Busy      = (state != ST_IDLE);
  assign FrameOdd  = frame_odd;
  assign Send0Data = send;

endmodule

// File: tb/tb_slant_transmitter.sv
// Scoreboard bench for slant_transmitter with a reduced frame geometry.
// Stimulus pushes the expected symbol stream of each frame; a negedge monitor
// pops one entry per symbol period and checks hold time, fetch strobes and idle outputs.
module tb_slant_transmitter;

  localparam int BIT_CLKS   = 4;
  localparam int LINE_SYMS  = 8;
  localparam int LINES      = 4;
  localparam int FRAME_SYMS = 24 + LINES * LINE_SYMS + (LINES - 1) * 24;
  localparam int FRAME_CLKS = FRAME_SYMS * BIT_CLKS;
  // Reset lands in the fourth data symbol of line 2.
  localparam int ABORT_AT   = (24 * 3 + 2 * LINE_SYMS + 3) * BIT_CLKS + 1;

  localparam logic [23:0] FRAME_EVEN_PAT = 24'haab155;
  localparam logic [23:0] FRAME_ODD_PAT  = 24'haa8d55;
  localparam logic [23:0] HSYNC_PAT      = 24'h000055;
  localparam logic [4:0]  POISON_Y       = 5'h1f;  // never a valid Y in this geometry
  localparam logic [4:0]  POISON_C       = 5'h00;  // never a valid C in this geometry

  typedef struct {
    logic [5:0]  sym;
    bit          is_data;
    logic [15:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        Busy;
  logic        FrameOdd;
  logic        TxRead;
  logic [15:0] TxAddr;
  logic [4:0]  TxYData;
  logic [4:0]  TxCData;
  logic [5:0]  Send0Data;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   aborting = 1'b0;

  int         phase = 0;
  int         sym_cnt = 0;
  bit         prev_busy = 1'b0;
  bit         hold_ok = 1'b1;
  bit         exp_rd;
  logic [5:0] hold_sym = '0;
  exp_t       cur;
  bit         buf_hold = 1'b0;

  slant_transmitter #(
    .BIT_CLKS  (BIT_CLKS),
    .LINE_SYMS (LINE_SYMS),
    .LINES     (LINES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .Busy      (Busy),
    .FrameOdd  (FrameOdd),
    .TxRead    (TxRead),
    .TxAddr    (TxAddr),
    .TxYData   (TxYData),
    .TxCData   (TxCData),
    .Send0Data (Send0Data)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},  32'(Busy),      0);
    check({tag, "_odd"},   32'(FrameOdd),  0);
    check({tag, "_read"},  32'(TxRead),    0);
    check({tag, "_addr"},  32'(TxAddr),    0);
    check({tag, "_sym"},   32'(Send0Data), 0);
  endtask

  // Expected stream for one frame: Y = addr[4:0], C = ~addr[4:0] from the buffer model.
  task automatic push_frame(input bit odd);
    logic [23:0] fpat;
    logic [23:0] hpat;
    exp_t e;
    fpat = odd ? FRAME_ODD_PAT : FRAME_EVEN_PAT;
    hpat = HSYNC_PAT;
    for (int i = 0; i < 24; i++) begin
      e.sym = {fpat[23 - i], 5'b0}; e.is_data = 1'b0; e.addr = '0;
      exp_q.push_back(e);
    end
    for (int l = 0; l < LINES; l++) begin
      if (l > 0) begin
        for (int i = 0; i < 24; i++) begin
          e.sym = {hpat[23 - i], 5'b0}; e.is_data = 1'b0; e.addr = '0;
          exp_q.push_back(e);
        end
      end
      for (int s = 0; s < LINE_SYMS; s++) begin
        e.addr    = 16'(l * (LINE_SYMS / 2) + s / 2);
        e.sym     = {1'b0, (s % 2 == 1) ? ~e.addr[4:0] : e.addr[4:0]};
        e.is_data = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  // Called just after a clock edge with the DUT idle; returns just after the accepting edge.
  task automatic start_frame(input bit odd);
    check("idle_before_start", 32'(Busy), 0);
    push_frame(odd);
    Start = 1'b1;
    cycles(1);
    Start = 1'b0;
    check("busy_rise", 32'(Busy), 1);
    check("frame_parity", 32'(FrameOdd), 32'(odd));
  endtask

  // Frame buffer: data valid from the TxRead cycle through the following cycle, poison otherwise.
  initial begin
    TxYData = POISON_Y;
    TxCData = POISON_C;
    forever begin
      @(negedge clk);
      if (TxRead === 1'b1) begin
        TxYData  = TxAddr[4:0];
        TxCData  = ~TxAddr[4:0];
        buf_hold = 1'b1;
      end else if (buf_hold) begin
        buf_hold = 1'b0;
      end else begin
        TxYData = POISON_Y;
        TxCData = POISON_C;
      end
    end
  end

  // Monitor: one scoreboard pop per symbol period while Busy, idle checks otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        phase     = 0;
        prev_busy = 1'b0;
      end else if (Busy === 1'b1) begin
        if (!prev_busy) sym_cnt = 0;
        if (phase == 0) begin
          check("exp_avail", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("symbol", 32'(Send0Data), 32'(cur.sym));
            sym_cnt++;
          end
          hold_sym = Send0Data;
          hold_ok  = 1'b1;
        end else if (Send0Data !== hold_sym) begin
          hold_ok = 1'b0;
        end
        if (phase == BIT_CLKS - 1) check("symbol_hold", 32'(hold_ok), 1);
        exp_rd = (phase == BIT_CLKS - 2) && (exp_q.size() != 0) && exp_q[0].is_data;
        check("tx_read", 32'(TxRead), 32'(exp_rd));
        if (exp_rd && TxRead === 1'b1) check("tx_addr", 32'(TxAddr), 32'(exp_q[0].addr));
        phase = (phase == BIT_CLKS - 1) ? 0 : phase + 1;
        prev_busy = 1'b1;
      end else begin
        if (prev_busy && !aborting) check("frame_length", 32'(sym_cnt), FRAME_SYMS);
        check("idle_sym", 32'(Send0Data), 0);
        check("idle_read", 32'(TxRead), 0);
        phase     = 0;
        prev_busy = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    cycles(3);
    check_reset_values("por");
    rst = 1'b0;
    cycles(100);

    // Frame A, even: Start pulses mid-frame and on the edge Busy falls are ignored.
    start_frame(1'b0);
    cycles(50);
    Start = 1'b1; cycles(1); Start = 1'b0;
    cycles(200);
    Start = 1'b1; cycles(1); Start = 1'b0;
    cycles(FRAME_CLKS - 1 - 252);
    Start = 1'b1;
    cycles(1);
    Start = 1'b0;
    check("a_busy_fall", 32'(Busy), 0);
    check("a_end_sym", 32'(Send0Data), 0);
    check("a_parity_toggle", 32'(FrameOdd), 1);
    cycles(10);
    check("a_start_ignored", 32'(Busy), 0);

    // Frame B, odd; Frame C starts on the first cycle after Busy falls.
    start_frame(1'b1);
    cycles(FRAME_CLKS);
    check("b_busy_fall", 32'(Busy), 0);
    check("b_parity_toggle", 32'(FrameOdd), 0);
    start_frame(1'b0);
    cycles(FRAME_CLKS);
    check("c_busy_fall", 32'(Busy), 0);
    check("c_parity_toggle", 32'(FrameOdd), 1);
    cycles(3);

    // Frame D, odd: reset during line 2 data.
    start_frame(1'b1);
    cycles(ABORT_AT);
    aborting = 1'b1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_reset_values("abort");
    exp_q.delete();
    cycles(2);
    aborting = 1'b0;

    // Frame E: restart from FRAME_EVEN at line 0.
    start_frame(1'b0);
    cycles(FRAME_CLKS);
    check("e_busy_fall", 32'(Busy), 0);
    check("e_parity_toggle", 32'(FrameOdd), 1);
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slant_transmitter.md
# slant_transmitter

Drone-side serial-symbol transmitter for one slant channel. It reads a 4:2:2-subsampled, 5-bit Y/C frame buffer and emits a 6-bit symbol stream. Each symbol holds for a fixed number of clocks. Bit 5 of each symbol carries frame and line sync patterns, and bits 4:0 carry pixel data. It sits between the camera frame buffer and the radio/link DAC and produces exactly the stream the ground-side slant receiver decodes.

## Interface
Parameters:
- BIT_CLKS, 25: clocks per symbol (receiver samples at count 0x14, default period 0x18+1).
- LINE_SYMS, 160: data symbols per line (80 Y + 80 C).
- LINES, 480: lines per frame.
- FRAME_EVEN, 24'haab155: frame sync pattern for even frames.
- FRAME_ODD, 24'haa8d55: frame sync pattern for odd frames.
- HSYNC, 24'h000055: line sync pattern.

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- Start  in  1  one-cycle pulse that begins a frame. It is honoured only when Busy=0.
- Busy  out  1  high from the cycle after an accepted Start to the end of the frame's last symbol.
- FrameOdd  out  1  parity of the current or last frame: 0 = even (FRAME_EVEN), 1 = odd.
- TxRead  out  1  one-cycle read strobe to the frame buffer.
- TxAddr  out  16  pixel-pair address, equal to line*80 + pixel index.
- TxYData  in  5  Y sample. Valid the cycle after TxRead.
- TxCData  in  5  C sample. Valid the cycle after TxRead.
- Send0Data  out  6  symbol output. Registered.

## Operation
- States: IDLE → FSYNC (24 symbols) → DATA (LINE_SYMS symbols) → LSYNC (24 symbols) → DATA … → IDLE.
  - FSYNC occurs once per frame.
  - LSYNC precedes each of lines 1..LINES-1.
  - After the last DATA symbol of line LINES-1, return to IDLE.
- Symbol timer: counts 0..BIT_CLKS-1 and wraps. A new symbol loads into Send0Data on the wrap to 0.
- Sync symbols: Send0Data = {pattern bit, 5'b0}, sent MSB first (bit 23 first for 24-bit patterns).
  - FSYNC sends FRAME_EVEN or FRAME_ODD according to FrameOdd.
  - LSYNC sends HSYNC: 16 zero bits, then 01010101.
- Data symbols: Send0Data = {1'b0, sample}.
  - Even symbol index within the line: Y.
  - Odd symbol index: C.
  - For symbol index s, TxAddr = line*80 + s/2.
- Fetch: TxRead pulses at timer count BIT_CLKS-2 before every DATA symbol.
  - The data is captured at BIT_CLKS-1 and presented at the wrap.
  - Only the needed half (Y or C) is used.
- FrameOdd:
  - Resets to 0.
  - Toggles when a frame completes normally.
  - Is latched at Start for the FSYNC pattern.
- IDLE output: Send0Data = 6'h00. TxRead = 0.
- Start while Busy: ignored. It is not queued.
- Reset mid-frame: the block returns to IDLE at the next edge. All outputs go to reset values and FrameOdd = 0. No partial frame is resumed.

## Timing
- Reset values: Busy=0, FrameOdd=0, TxRead=0, TxAddr=0, Send0Data=0.
- Start is accepted at edge t:
  - Busy=1 from t+1.
  - The first FSYNC symbol appears on Send0Data at t+1 and holds BIT_CLKS cycles.
- Frame length: 24 + LINES*LINE_SYMS + (LINES-1)*24 = 88320 symbols, which is 2,208,000 clocks at the defaults.
- Busy falls the cycle after the last data symbol's final clock. Send0Data returns to 0 in that same cycle.
- Start in the same cycle Busy falls is ignored. Start one cycle later is accepted.
- Bit-5 transitions occur only at symbol boundaries. Their spacing is an exact multiple of BIT_CLKS, which the receiver's bit-time averaging requires.
- Address arithmetic is 16-bit unsigned. The maximum is 38399; there is no wrap within a frame.

## Structure
- Shared package slant_link_pkg holds:
  - FRAME_EVEN, FRAME_ODD, HSYNC.
  - Sync length (24).
  - The state enum (IDLE/FSYNC/DATA/LSYNC).
  - Defaults for LINE_SYMS and LINES.
- The receiver imports the same package.
- One sub-module, slant_symbol_timer, holds the BIT_CLKS counter. It outputs sym_wrap, fetch (count BIT_CLKS-2) and capture (count BIT_CLKS-1) strobes.

## Test plan
- Reset, then idle for 100 cycles → Send0Data=0, Busy=0, TxRead=0 throughout.
- Start with FrameOdd=0 → bit5 of 24 consecutive symbols is 0xaab155, MSB first, each held exactly 25 clocks. The first symbol appears at t+1.
- Buffer model returning Y=addr[4:0] and C=~addr[4:0] → line 0 symbols alternate {0,Y},{0,C}. TxAddr runs 0..79. TxRead is one cycle wide at count 23.
- Complete frame → exactly 88320 symbols. Each of the 479 LSYNC blocks reads bit5 = 0x000055. Busy falls after the final symbol, and FrameOdd becomes 1. A second Start emits 0xaa8d55.
- Start pulsed mid-frame and at the cycle Busy falls → both ignored. No pattern restart.
- rst asserted during line 200 DATA → IDLE next edge. All outputs at reset values. A new Start yields FRAME_EVEN from line 0.
